// File: rtl/dram_pkg.sv
// Shared definitions for the SDRAM memory tester: request-interface widths,
// FSM state encoding and the test-pattern generator constants and helpers.
package dram_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] LFSR_POLY = 32'h80200003;
  localparam logic [DATA_W-1:0] LFSR_SEED = 32'hACE10001;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_WR_GAP = 3'd2,
    S_RD_REQ = 3'd3,
    S_RD_GAP = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // One right-shifting Galois step; taps are applied when bit 0 falls out.
  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v);
    lfsr_step = {1'b0, v[DATA_W-1:1]} ^ (v[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

  function automatic logic [DATA_W-1:0] addr_pattern(input logic [15:0] a);
    addr_pattern = {a ^ 16'hA5A5, ~a};
  endfunction

endpackage

// File: rtl/dram_memtest_pattern.sv
// Next-word test pattern selector. DRAM_MEMTEST_LFSR_EN selects a Galois LFSR
// sequence; otherwise the pattern is derived from the word address.
module dram_memtest_pattern
  import dram_pkg::*;
(
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_cur,
  input  logic              i_seed,
  input  logic              i_advance,
  output logic [DATA_W-1:0] o_pattern
);

`ifdef DRAM_MEMTEST_LFSR_EN
  logic w_unused_addr;
  assign w_unused_addr = ^i_addr;

  // Seed restarts the sequence; advance steps it once per word.
  always_comb begin
    if (i_seed) begin
      o_pattern = LFSR_SEED;
    end else if (i_advance) begin
      o_pattern = lfsr_step(i_cur);
    end else begin
      o_pattern = i_cur;
    end
  end
`else
  logic w_unused_addr;
  assign w_unused_addr = ^i_addr[ADDR_W-1:16];

  // The pattern is a pure function of the address being moved to.
  always_comb begin
    if (i_seed || i_advance) begin
      o_pattern = addr_pattern(i_addr[15:0]);
    end else begin
      o_pattern = i_cur;
    end
  end
`endif

endmodule

// File: rtl/dram_memtest.sv
// SDRAM memory tester: writes a pattern over [ADDR_LO, ADDR_HI], reads it back
// and reports errors. Pattern source is chosen by DRAM_MEMTEST_LFSR_EN.
module dram_memtest
  import dram_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_LO = 24'h000000,
  parameter logic [ADDR_W-1:0] ADDR_HI = 24'h0003FF,
  parameter int unsigned       TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_req_read,
  output logic              dram_req_write,
  output logic [DATA_W-1:0] dram_data_out,
  input  logic [DATA_W-1:0] dram_data_in,
  input  logic              dram_data_valid,
  input  logic              dram_write_complete
);

  localparam int TMO_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 32'd1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [DATA_W-1:0]  r_pattern;
  logic [DATA_W-1:0]  w_pattern_nxt;
  logic               w_seed;
  logic               w_advance;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic               r_timeout;
  logic [15:0]        r_err_count;
  logic [ADDR_W-1:0]  r_first_err_addr;
  logic               r_req_rd;
  logic               r_req_wr;
  logic               w_req_rd_nxt;
  logic               w_req_wr_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  logic w_start;
  logic w_wr_ack;
  logic w_rd_ack;
  logic w_in_req;
  logic w_tmo_hit;
  logic w_mismatch;
  logic w_at_hi;

  // Strobes only count in the phase that is waiting for them.
  assign w_start    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_wr_ack   = (r_state == S_WR_REQ) && dram_write_complete;
  assign w_rd_ack   = (r_state == S_RD_REQ) && dram_data_valid;
  assign w_in_req   = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
  assign w_tmo_hit  = w_in_req && !w_wr_ack && !w_rd_ack && (r_tmo_cnt == TMO_LAST);
  assign w_mismatch = w_rd_ack && (dram_data_in != r_pattern);
  assign w_at_hi    = (r_addr == ADDR_HI);

  dram_memtest_pattern u_pattern (
    .i_addr    (w_addr_nxt),
    .i_cur     (r_pattern),
    .i_seed    (w_seed),
    .i_advance (w_advance),
    .o_pattern (w_pattern_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_WR_REQ;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_WR_REQ: begin
        if (w_wr_ack) begin
          w_state_nxt = S_WR_GAP;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WR_REQ;
        end
      end
      S_WR_GAP: begin
        if (w_at_hi) begin
          w_state_nxt = S_RD_REQ;
        end else begin
          w_state_nxt = S_WR_REQ;
        end
      end
      S_RD_REQ: begin
        if (w_rd_ack) begin
          w_state_nxt = S_RD_GAP;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RD_REQ;
        end
      end
      S_RD_GAP: begin
        if (w_at_hi) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RD_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath controls; request levels follow the state being entered.
  always_comb begin
    w_addr_nxt = r_addr;
    w_seed     = 1'b0;
    w_advance  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_addr_nxt = ADDR_LO;
          w_seed     = 1'b1;
        end else begin
          w_addr_nxt = r_addr;
        end
      end
      S_WR_GAP: begin
        if (w_at_hi) begin
          w_addr_nxt = ADDR_LO;
          w_seed     = 1'b1;
        end else begin
          w_addr_nxt = r_addr + 24'd1;
          w_advance  = 1'b1;
        end
      end
      S_RD_GAP: begin
        if (w_at_hi) begin
          w_addr_nxt = r_addr;
        end else begin
          w_addr_nxt = r_addr + 24'd1;
          w_advance  = 1'b1;
        end
      end
      default: w_addr_nxt = r_addr;
    endcase
    w_req_wr_nxt = (w_state_nxt == S_WR_REQ);
    w_req_rd_nxt = (w_state_nxt == S_RD_REQ);
    w_done_nxt   = (w_state_nxt == S_DONE);
    w_busy_nxt   = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
  end

  // Registered request interface, address/pattern and response timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= 24'd0;
      r_pattern <= 32'd0;
      r_req_wr  <= 1'b0;
      r_req_rd  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_addr    <= w_addr_nxt;
      r_pattern <= w_pattern_nxt;
      r_req_wr  <= w_req_wr_nxt;
      r_req_rd  <= w_req_rd_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      if (!w_in_req || w_wr_ack || w_rd_ack || w_tmo_hit) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  // Result tracking; the first mismatch is the one seen while the count is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count      <= 16'd0;
      r_first_err_addr <= 24'd0;
      r_timeout        <= 1'b0;
      r_pass           <= 1'b0;
    end else begin
      if (w_start) begin
        r_err_count      <= 16'd0;
        r_first_err_addr <= 24'd0;
        r_timeout        <= 1'b0;
      end else begin
        if (w_tmo_hit) begin
          r_timeout <= 1'b1;
        end
        if (w_mismatch) begin
          if (r_err_count != 16'hFFFF) begin
            r_err_count <= r_err_count + 16'd1;
          end
          if (r_err_count == 16'd0) begin
            r_first_err_addr <= r_addr;
          end
        end
      end
      r_pass <= w_done_nxt && !w_start && (r_err_count == 16'd0) && !r_timeout && !w_tmo_hit;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;
  assign dram_addr      = r_addr;
  assign dram_req_read  = r_req_rd;
  assign dram_req_write = r_req_wr;
  assign dram_data_out  = r_pattern;

endmodule

// File: tb/tb_dram_memtest.sv
// Self-checking bench for dram_memtest: a randomized DRAM responder with an
// array-backed memory, spurious strobes and read corruption, checked against expectations.
module tb_dram_memtest;

  localparam logic [23:0] LO  = 24'h000000;
  localparam logic [23:0] HI  = 24'h000003;
  localparam int          NW  = 4;
  localparam int          TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [23:0] first_err_addr, dram_addr;
  logic        dram_req_read, dram_req_write;
  logic [31:0] dram_data_out, dram_data_in;
  logic        dram_data_valid, dram_write_complete;

  int n_checks = 0;
  int n_errors = 0;

  // Responder controls and statistics.
  bit          silent = 1'b0;
  bit          spurious = 1'b0;
  logic [3:0]  corrupt_mask = 4'b0000;
  int          wr_cnt, rd_cnt, proto_err, order_err;
  logic [31:0] mem [NW];

  dram_memtest #(.ADDR_LO(LO), .ADDR_HI(HI), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .dram_addr(dram_addr), .dram_req_read(dram_req_read), .dram_req_write(dram_req_write),
    .dram_data_out(dram_data_out), .dram_data_in(dram_data_in),
    .dram_data_valid(dram_data_valid), .dram_write_complete(dram_write_complete)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "/busy"}, busy, 1'b0);
    check_eq({tag, "/done"}, done, 1'b0);
    check_eq({tag, "/pass"}, pass, 1'b0);
    check_eq({tag, "/timeout"}, timeout, 1'b0);
    check_eq({tag, "/req_rd"}, dram_req_read, 1'b0);
    check_eq({tag, "/req_wr"}, dram_req_write, 1'b0);
    check_eq({tag, "/err_count"}, err_count, 16'd0);
    check_eq({tag, "/first_err"}, first_err_addr, 24'd0);
    check_eq({tag, "/addr"}, dram_addr, 24'd0);
    check_eq({tag, "/data_out"}, dram_data_out, 32'd0);
  endtask

  // Responder + protocol monitor, acting on falling edges.
  initial begin : responder
    int   lat, age;
    bit   strobed, prev_req;
    logic [23:0] prev_addr;
    logic [31:0] prev_data;
    lat = 1; age = 0; strobed = 1'b0; prev_req = 1'b0;
    prev_addr = 24'd0; prev_data = 32'd0;
    dram_data_valid = 1'b0; dram_write_complete = 1'b0; dram_data_in = 32'd0;
    forever begin
      @(negedge clk);
      dram_data_valid = 1'b0;
      dram_write_complete = 1'b0;
      if (dram_req_read && dram_req_write) proto_err++;
      if (strobed && (dram_req_read || dram_req_write)) proto_err++;
      strobed = 1'b0;
      if (dram_req_read || dram_req_write) begin
        if (prev_req && (dram_addr !== prev_addr ||
                         (dram_req_write && dram_data_out !== prev_data))) proto_err++;
        if (!prev_req) begin
          age = 0;
          lat = $urandom_range(1, 5);
        end
        prev_req = 1'b1; prev_addr = dram_addr; prev_data = dram_data_out;
        age++;
        if (!silent && age == lat) begin
          strobed = 1'b1;
          if (dram_req_write) begin
            if (wr_cnt >= NW || dram_addr != LO + 24'(wr_cnt)) order_err++;
            else mem[wr_cnt] = dram_data_out;
            wr_cnt++;
            dram_write_complete = 1'b1;
          end else begin
            if (rd_cnt >= NW || dram_addr != LO + 24'(rd_cnt)) order_err++;
            else dram_data_in = mem[rd_cnt] ^ {31'd0, corrupt_mask[rd_cnt]};
            rd_cnt++;
            dram_data_valid = 1'b1;
          end
        end else if (spurious && $urandom_range(0, 1) == 1) begin
          if (dram_req_write) begin
            dram_data_valid = 1'b1;
            dram_data_in = $urandom;
          end else begin
            dram_write_complete = 1'b1;
          end
        end
      end else begin
        prev_req = 1'b0;
        if (spurious && $urandom_range(0, 1) == 1) begin
          dram_data_valid = 1'b1;
          dram_data_in = $urandom;
        end
      end
    end
  end

  task automatic prepare(input logic [3:0] mask, input bit spur, input bit quiet);
    corrupt_mask = mask; spurious = spur; silent = quiet;
    wr_cnt = 0; rd_cnt = 0; proto_err = 0; order_err = 0;
    for (int i = 0; i < NW; i++) mem[i] = 32'd0;
  endtask

  task automatic run_test(input string tag, input logic [3:0] mask, input bit spur,
                          input bit quiet, input bit poke);
    int cyc, wr_hi, exp_err;
    logic [23:0] exp_first;
    bit found, exp_pass;
    prepare(mask, spur, quiet);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "/start_busy"}, busy, 1'b1);
    check_eq({tag, "/start_req_wr"}, dram_req_write, 1'b1);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; wr_hi = 0;
    while (!done && cyc < 2000) begin
      if (dram_req_write) wr_hi++;
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 10 || cyc == 11);
    end
    start = 1'b0;
    check_eq({tag, "/finished"}, cyc < 2000, 1'b1);

    exp_err = 0; exp_first = 24'd0; found = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (!quiet && mask[i]) begin
        exp_err++;
        if (!found) begin
          exp_first = LO + 24'(i);
          found = 1'b1;
        end
      end
    end
    exp_pass = !quiet && exp_err == 0;

    check_eq({tag, "/done"}, done, 1'b1);
    check_eq({tag, "/busy"}, busy, 1'b0);
    check_eq({tag, "/pass"}, pass, exp_pass);
    check_eq({tag, "/timeout"}, timeout, quiet);
    check_eq({tag, "/err_count"}, err_count, 16'(exp_err));
    check_eq({tag, "/first_err"}, first_err_addr, exp_first);
    check_eq({tag, "/reqs_low"}, {dram_req_read, dram_req_write}, 2'b00);
    check_eq({tag, "/writes"}, wr_cnt, quiet ? 0 : NW);
    check_eq({tag, "/reads"}, rd_cnt, quiet ? 0 : NW);
    check_eq({tag, "/protocol"}, proto_err, 0);
    check_eq({tag, "/order"}, order_err, 0);
    if (quiet) check_eq({tag, "/req_wr_cycles"}, wr_hi, TMO);
    else for (int i = 0; i < NW; i++)
      check_eq($sformatf("%s/mem%0d", tag, i), mem[i], exp_word(LO + 24'(i)));
    repeat (3) @(negedge clk);
    check_eq({tag, "/done_held"}, {done, pass}, {1'b1, exp_pass});
  endtask

  initial begin : main
    int cyc;
    logic [31:0] lit;
    rst = 1'b1; start = 1'b0;
    prepare(4'b0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_no_start", {busy, done, dram_req_write}, 3'b000);

    run_test("ideal", 4'b0000, 1'b0, 1'b0, 1'b0);
    lit = 32'hA5A5FFFF; check_eq("ideal/word0_lit", mem[0], lit);
    lit = 32'hA5A7FFFD; check_eq("ideal/word2_lit", mem[2], lit);
    lit = 32'hA5A6FFFC; check_eq("ideal/word3_lit", mem[3], lit);

    run_test("corrupt2", 4'b0100, 1'b0, 1'b0, 1'b0);
    run_test("timeout", 4'b0000, 1'b0, 1'b1, 1'b0);
    run_test("spurious", 4'b0000, 1'b1, 1'b0, 1'b1);

    // Reset pulsed during the third read.
    prepare(4'b0000, 1'b0, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(dram_req_read && dram_addr == LO + 24'd2) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("midrst/reached_read2", cyc < 2000, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    @(negedge clk); rst = 1'b0;
    run_test("after_rst", 4'b0000, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++)
      run_test($sformatf("rand%0d", r), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
